bsg_nonsynth_waveform_trace_sched: RTL and testbench
====================================================

# bsg_nonsynth_waveform_trace_sched

Non-synthesizable scheduler that sequences the waveform tracer's enable input. It accepts a run-time configuration (delay, window length, gap, repeat count) and is armed by a host or testbench write. After a trigger it produces a registered `en_o` pulse train: one or more trace windows separated by gaps. It sits in the cosim top next to the tracer, and `en_o` connects directly to the tracer's `en_i`.

## Interface
Parameters:
- `cnt_width_p`, 32: width of the delay, window and gap counters.
- `rpt_width_p`, 16: width of the repeat count and the window counter.

Ports:
- `clk_i` in 1: clock. One clock domain only.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `cfg_v_i` in 1: configuration write strobe.
- `cfg_delay_i` in `cnt_width_p`: cycles from trigger to the first window.
- `cfg_window_i` in `cnt_width_p`: length of each window in cycles. 0 is treated as 1.
- `cfg_gap_i` in `cnt_width_p`: cycles between windows.
- `cfg_repeat_i` in `rpt_width_p`: number of windows. 0 means unlimited.
- `arm_i` in 1: arm request.
- `trigger_i` in 1: start event, level-sampled.
- `abort_i` in 1: return to IDLE immediately.
- `cfg_ready_o` out 1: high when the block is in IDLE or DONE.
- `en_o` out 1: trace enable, registered; connects to the tracer's `en_i`.
- `state_o` out 3: encoded state. IDLE=0, ARMED=1, DELAY=2, ON=3, GAP=4, DONE=5.
- `windows_o` out `rpt_width_p`: number of windows completed since the last arm.
- `done_o` out 1: high while in DONE.

## Operation
- **Reset** (asserts asynchronously, releases on the next clock edge):
  - State goes to IDLE.
  - All outputs go to 0 except `cfg_ready_o`, which is 1.
  - Config registers go to 0.
  - Down-counter goes to 0.
- **Config write:** `cfg_v_i` in IDLE or DONE latches all four cfg fields at the edge. In any other state the write is ignored.
- **State transitions:**
  - IDLE or DONE + `arm_i` → ARMED; `windows_o` clears to 0.
  - ARMED + `trigger_i`: if delay = 0, go to ON and load the counter with window−1. Otherwise go to DELAY and load the counter with delay−1.
  - DELAY: decrement each cycle. At 0, go to ON and load window−1.
  - ON: `en_o` = 1. Decrement each cycle. At 0, `windows_o` increments by one, then:
    - if repeat ≠ 0 and the new count equals repeat → DONE;
    - else if gap = 0 → ON with the counter reloaded to window−1, so `en_o` stays high;
    - else → GAP with the counter loaded to gap−1.
  - GAP: decrement each cycle. At 0, go to ON and load window−1.
- **Abort:** `abort_i` sends any state to IDLE at the next edge.
- **Priority:** abort > arm > trigger > counter expiry.
- **Ignored inputs:**
  - `trigger_i` outside ARMED (no retrigger).
  - `arm_i` outside IDLE or DONE.
- **Output decode:** `en_o`, `done_o`, `cfg_ready_o` and `state_o` decode only from the state register. No combinational path from any input to any output.
- **Window counter:**
  - With repeat = 0, `windows_o` saturates at all-ones and does not wrap.
  - With repeat ≠ 0, it stops at repeat.
- **Simultaneous `cfg_v_i` + `arm_i` in IDLE:** the new config is latched and the block arms; the new values apply at the trigger.
- **Unlimited mode:** `done_o` never rises when repeat = 0; only abort or reset exits.

## Timing
- Trigger sampled high at edge k, delay D: `en_o` rises after edge k+D+1 and stays high for exactly W cycles (W = max(window, 1)).
- Each gap is exactly G low cycles between windows.
- `windows_o` updates on the same edge that `en_o` falls, or on the edge that reloads ON when G = 0.
- DONE is entered on the edge `en_o` falls after the last window. `done_o` and `cfg_ready_o` rise on that same edge.
- Abort or reset during ON: `en_o` is 0 in the next cycle, or immediately on reset assertion.
- Reset release: first sampled edge is in IDLE; `arm_i` at the first post-reset edge is honored.

## Test plan
- **Basic three-window run:**
  - Stimulus: cfg delay=3, window=5, gap=2, repeat=3; arm, then trigger at edge 10.
  - Response: `en_o` high during cycles 14–18, 21–25 and 28–32.
  - `windows_o` reads 1, 2, 3; `done_o` is high from cycle 33; `cfg_ready_o` = 1.
- **Zero-value fields:**
  - Stimulus: delay=0, window=0, gap=0, repeat=2; trigger at edge 5.
  - Response: `en_o` high for cycles 6–7 continuously; DONE at cycle 8; `windows_o` = 2.
- **Abort and reset mid-window:**
  - Stimulus: abort in the 3rd cycle of a window=10 window.
  - Response: `en_o` low the next cycle; `state_o` = 0; a later trigger is ignored until re-armed.
  - Repeat the stimulus with `reset_n_i` pulsed between clock edges: `en_o` drops immediately and all outputs take their reset values.
- **Ignored writes and triggers:**
  - Stimulus: cfg write during DELAY; trigger while in ON.
  - Response: the running schedule is unchanged (original window length is kept) and there is no restart.
  - After DONE, a new cfg plus arm takes effect and `windows_o` clears to 0.
- **Unlimited mode with saturation:**
  - Stimulus: repeat=0, window=1, gap=1, `rpt_width_p`=4; run 40 cycles past the trigger.
  - Response: `windows_o` saturates at 15; `done_o` stays 0; `en_o` keeps toggling every cycle.

Source files
------------

// File: rtl/bsg_nonsynth_waveform_trace_sched.sv
// Trace-window scheduler: drives the waveform tracer's enable with a
// delay / window / gap / repeat pulse train after an armed trigger.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for arm; config writes accepted
// ARMED | waiting for trigger
// DELAY | counting down the trigger-to-first-window delay
// ON    | trace window active, en_o high
// GAP   | counting down the low time between windows
// DONE  | requested number of windows completed; config writes accepted
module bsg_nonsynth_waveform_trace_sched #(
  parameter int cnt_width_p = 32,
  parameter int rpt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   cfg_v_i,
  input  logic [cnt_width_p-1:0] cfg_delay_i,
  input  logic [cnt_width_p-1:0] cfg_window_i,
  input  logic [cnt_width_p-1:0] cfg_gap_i,
  input  logic [rpt_width_p-1:0] cfg_repeat_i,
  input  logic                   arm_i,
  input  logic                   trigger_i,
  input  logic                   abort_i,
  output logic                   cfg_ready_o,
  output logic                   en_o,
  output logic [2:0]             state_o,
  output logic [rpt_width_p-1:0] windows_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_ON    = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [cnt_width_p-1:0] lp_cnt_one = cnt_width_p'(1);
  localparam logic [rpt_width_p-1:0] lp_rpt_one = rpt_width_p'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [cnt_width_p-1:0] r_cnt;
  logic [cnt_width_p-1:0] w_cnt_nxt;
  logic [rpt_width_p-1:0] r_windows;
  logic [rpt_width_p-1:0] w_windows_nxt;
  logic [rpt_width_p-1:0] w_windows_inc;

  logic [cnt_width_p-1:0] r_cfg_delay;
  logic [cnt_width_p-1:0] r_cfg_window;
  logic [cnt_width_p-1:0] r_cfg_gap;
  logic [rpt_width_p-1:0] r_cfg_repeat;

  logic                   w_cfg_open;
  logic                   w_cnt_zero;
  logic [cnt_width_p-1:0] w_win_m1;

  assign w_cfg_open    = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_cnt_zero    = (r_cnt == '0);
  // A zero window length behaves as a one-cycle window.
  assign w_win_m1      = (r_cfg_window == '0) ? '0 : (r_cfg_window - lp_cnt_one);
  // Window count saturates instead of wrapping in unlimited mode.
  assign w_windows_inc = (r_windows == '1) ? r_windows : (r_windows + lp_rpt_one);

  // Config registers: only writable while the scheduler is not running.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cfg_delay  <= '0;
      r_cfg_window <= '0;
      r_cfg_gap    <= '0;
      r_cfg_repeat <= '0;
    end else if (cfg_v_i && w_cfg_open) begin
      r_cfg_delay  <= cfg_delay_i;
      r_cfg_window <= cfg_window_i;
      r_cfg_gap    <= cfg_gap_i;
      r_cfg_repeat <= cfg_repeat_i;
    end
  end

  // State, down-counter and window-count registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_windows <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_windows <= w_windows_nxt;
    end
  end

  // Next-state logic; abort outranks arm, arm outranks trigger, trigger outranks expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_windows_nxt = r_windows;
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            w_state_nxt   = ST_ARMED;
            w_windows_nxt = '0;
          end
        end
        ST_ARMED: begin
          if (trigger_i) begin
            if (r_cfg_delay == '0) begin
              w_state_nxt = ST_ON;
              w_cnt_nxt   = w_win_m1;
            end else begin
              w_state_nxt = ST_DELAY;
              w_cnt_nxt   = r_cfg_delay - lp_cnt_one;
            end
          end
        end
        ST_DELAY, ST_GAP: begin
          if (w_cnt_zero) begin
            w_state_nxt = ST_ON;
            w_cnt_nxt   = w_win_m1;
          end else begin
            w_cnt_nxt = r_cnt - lp_cnt_one;
          end
        end
        ST_ON: begin
          if (w_cnt_zero) begin
            w_windows_nxt = w_windows_inc;
            if ((r_cfg_repeat != '0) && (w_windows_inc == r_cfg_repeat)) begin
              w_state_nxt = ST_DONE;
            end else if (r_cfg_gap == '0) begin
              w_cnt_nxt = w_win_m1;
            end else begin
              w_state_nxt = ST_GAP;
              w_cnt_nxt   = r_cfg_gap - lp_cnt_one;
            end
          end else begin
            w_cnt_nxt = r_cnt - lp_cnt_one;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // All outputs are decoded from registers only.
  assign en_o        = (r_state == ST_ON);
  assign done_o      = (r_state == ST_DONE);
  assign cfg_ready_o = w_cfg_open;
  assign state_o     = r_state;
  assign windows_o   = r_windows;

endmodule

// File: tb/tb_bsg_nonsynth_waveform_trace_sched.sv
// Self-checking bench for the trace scheduler: table-driven runs, random runs
// against a timeline model, and directed abort / reset / ignored-input sequences.
module tb_bsg_nonsynth_waveform_trace_sched;

  localparam int CW = 32;
  localparam int RW = 4;
  localparam int SAT = (1 << RW) - 1;

  logic          clk_i;
  logic          reset_n_i;
  logic          cfg_v_i;
  logic [CW-1:0] cfg_delay_i;
  logic [CW-1:0] cfg_window_i;
  logic [CW-1:0] cfg_gap_i;
  logic [RW-1:0] cfg_repeat_i;
  logic          arm_i;
  logic          trigger_i;
  logic          abort_i;
  logic          cfg_ready_o;
  logic          en_o;
  logic [2:0]    state_o;
  logic [RW-1:0] windows_o;
  logic          done_o;

  int n_total = 0;
  int n_pass  = 0;

  bsg_nonsynth_waveform_trace_sched #(.cnt_width_p(CW), .rpt_width_p(RW)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .cfg_v_i      (cfg_v_i),
    .cfg_delay_i  (cfg_delay_i),
    .cfg_window_i (cfg_window_i),
    .cfg_gap_i    (cfg_gap_i),
    .cfg_repeat_i (cfg_repeat_i),
    .arm_i        (arm_i),
    .trigger_i    (trigger_i),
    .abort_i      (abort_i),
    .cfg_ready_o  (cfg_ready_o),
    .en_o         (en_o),
    .state_o      (state_o),
    .windows_o    (windows_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Timeline model: c counts clock edges after the trigger-sampling edge
  // (c = 0 is the cycle right after it). Window j spans
  // [D + j*P, D + j*P + W - 1] with W = max(window,1), P = W + G.
  function automatic int m_state(int c, int d, int w, int g, int r);
    int ww, p, x;
    ww = (w == 0) ? 1 : w;
    p  = ww + g;
    if (r != 0 && c >= d + (r - 1) * p + ww) return 5;
    if (c < d) return 2;
    x = (c - d) % p;
    return (x < ww) ? 3 : 4;
  endfunction

  function automatic int m_windows(int c, int d, int w, int g, int r);
    int ww, p, n;
    ww = (w == 0) ? 1 : w;
    p  = ww + g;
    if (c < d + ww) return 0;
    n = (c - d - ww) / p + 1;
    if (r != 0 && n > r) n = r;
    if (n > SAT) n = SAT;
    return n;
  endfunction

  // Leaves the bench at a negedge with the DUT armed on the given config.
  task automatic setup(input int d, input int w, input int g, input int r, input bit do_abort);
    if (do_abort) begin
      @(negedge clk_i);
      abort_i = 1'b1;
    end
    @(negedge clk_i);
    abort_i      = 1'b0;
    cfg_v_i      = 1'b1;
    cfg_delay_i  = CW'(d);
    cfg_window_i = CW'(w);
    cfg_gap_i    = CW'(g);
    cfg_repeat_i = RW'(r);
    arm_i        = 1'b1;
    @(negedge clk_i);
    cfg_v_i = 1'b0;
    arm_i   = 1'b0;
    chk("armed_state", int'(state_o), 1);
    chk("armed_windows", int'(windows_o), 0);
  endtask

  // Trigger, then compare every cycle against the model for len cycles.
  // disturb: config write during DELAY, trigger and arm during ON.
  task automatic run(input int d, input int w, input int g, input int r,
                     input int len, input bit disturb);
    int s;
    trigger_i = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk_i);
      if (c == 0) trigger_i = 1'b0;
      if (disturb && c == 1) cfg_v_i = 1'b0;
      if (disturb && c == d + 1) begin trigger_i = 1'b0; arm_i = 1'b0; end
      s = m_state(c, d, w, g, r);
      chk($sformatf("state c=%0d", c), int'(state_o), s);
      chk($sformatf("en c=%0d", c), int'(en_o), (s == 3) ? 1 : 0);
      chk($sformatf("done c=%0d", c), int'(done_o), (s == 5) ? 1 : 0);
      chk($sformatf("ready c=%0d", c), int'(cfg_ready_o), (s == 5) ? 1 : 0);
      chk($sformatf("windows c=%0d", c), int'(windows_o), m_windows(c, d, w, g, r));
      if (disturb && c == 0) begin
        cfg_v_i      = 1'b1;
        cfg_delay_i  = '0;
        cfg_window_i = CW'(2);
        cfg_gap_i    = '0;
        cfg_repeat_i = RW'(1);
      end
      if (disturb && c == d) begin trigger_i = 1'b1; arm_i = 1'b1; end
    end
  endtask

  typedef struct {
    int d, w, g, r, len, exp_win, exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{d:3, w:5, g:2, r:3, len:25, exp_win:3,  exp_done:1};
    vecs[1] = '{d:0, w:0, g:0, r:2, len:6,  exp_win:2,  exp_done:1};
    vecs[2] = '{d:0, w:1, g:1, r:0, len:45, exp_win:15, exp_done:0};
    vecs[3] = '{d:2, w:3, g:0, r:4, len:20, exp_win:4,  exp_done:1};
    vecs[4] = '{d:1, w:2, g:3, r:1, len:10, exp_win:1,  exp_done:1};

    reset_n_i = 1'b0; cfg_v_i = 1'b0; cfg_delay_i = '0; cfg_window_i = '0;
    cfg_gap_i = '0; cfg_repeat_i = '0; arm_i = 1'b0; trigger_i = 1'b0; abort_i = 1'b0;

    #3;
    chk("rst_state", int'(state_o), 0);
    chk("rst_ready", int'(cfg_ready_o), 1);
    chk("rst_en", int'(en_o), 0);
    chk("rst_windows", int'(windows_o), 0);
    chk("rst_done", int'(done_o), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      setup(vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].r, 1'b1);
      run(vecs[i].d, vecs[i].w, vecs[i].g, vecs[i].r, vecs[i].len, 1'b0);
      chk($sformatf("vec%0d_final_windows", i), int'(windows_o), vecs[i].exp_win);
      chk($sformatf("vec%0d_final_done", i), int'(done_o), vecs[i].exp_done);
    end

    // Abort in the third cycle of a long window; later trigger ignored.
    setup(0, 10, 0, 1, 1'b1);
    trigger_i = 1'b1;
    @(negedge clk_i); trigger_i = 1'b0;
    chk("abort_pre_en", int'(en_o), 1);
    @(negedge clk_i);
    @(negedge clk_i);
    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    chk("abort_en", int'(en_o), 0);
    chk("abort_state", int'(state_o), 0);
    trigger_i = 1'b1;
    @(negedge clk_i); trigger_i = 1'b0;
    @(negedge clk_i);
    chk("abort_trig_ignored_state", int'(state_o), 0);
    chk("abort_trig_ignored_en", int'(en_o), 0);

    // Re-arm, start a window, then assert reset between clock edges.
    arm_i = 1'b1;
    @(negedge clk_i); arm_i = 1'b0;
    chk("rearm_state", int'(state_o), 1);
    trigger_i = 1'b1;
    @(negedge clk_i); trigger_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("prerst_en", int'(en_o), 1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("async_rst_en", int'(en_o), 0);
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_ready", int'(cfg_ready_o), 1);
    chk("async_rst_windows", int'(windows_o), 0);
    chk("async_rst_done", int'(done_o), 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    arm_i     = 1'b1;
    @(negedge clk_i); arm_i = 1'b0;
    chk("post_rst_arm", int'(state_o), 1);

    // Ignored config write during DELAY and trigger/arm during ON, then re-arm from DONE.
    setup(4, 6, 1, 2, 1'b1);
    run(4, 6, 1, 2, 20, 1'b1);
    chk("ign_done", int'(done_o), 1);
    setup(1, 2, 0, 1, 1'b0);
    run(1, 2, 0, 1, 6, 1'b0);

    // Random runs against the timeline model.
    for (int i = 0; i < 20; i++) begin
      int d, w, g, r;
      d = $urandom_range(0, 5);
      w = $urandom_range(0, 4);
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 4);
      setup(d, w, g, r, 1'b1);
      run(d, w, g, r, 30, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
